alu_cmd_sequencer: RTL and testbench

- Upstream/downstream wrapper stage for the 6-bit combinational ALU.
- Buffers ALU commands (control, operand A, operand B) in a small FIFO under a valid/ready handshake.
- Drives one command per cycle into the ALU and registers the ALU's out/carry/zero into a result stage with its own valid/ready handshake.
- Provides an accumulator mode in which operand A is replaced by the last registered ALU result, so chained operations need no host round-trip.

---
 rtl/alu_cmd_sequencer_if.sv | 25 ++
 rtl/alu_cmd_sequencer.sv | 112 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle between a host and the ALU command sequencer.
`timescale 1ns/1ps
interface alu_cmd_sequencer_if #(parameter int WIDTH = 6);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_ctrl;
  logic             in_acc_sel;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             res_zero;

  modport master (
    output in_valid, in_ctrl, in_acc_sel, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, res_carry, res_zero
  );

  modport slave (
    input  in_valid, in_ctrl, in_acc_sel, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, res_carry, res_zero
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Wrapper around the combinational ALU: command FIFO in, registered result stage out,
// with an accumulator that can stand in for operand A to chain operations.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_cmd_sequencer_if.slave       bus,
  input  logic                     acc_clr,
  output logic [3:0]               alu_ctrl,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0]       ctrl;
    logic             acc_sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic [WIDTH-1:0] acc;
  logic             empty;
  logic             push;
  logic             issue;

  // in_ready depends on the stored level only, so a pop never opens a slot in the same cycle.
  assign bus.in_ready = (level != FULL);
  assign empty        = (level == '0);
  assign push         = bus.in_valid && bus.in_ready;
  assign issue        = !empty && (!bus.res_valid || bus.res_ready);
  assign head         = mem[rd_ptr];
  assign fifo_level   = level;

  always_comb begin
    alu_ctrl = '0;
    alu_a    = '0;
    alu_b    = '0;
    if (!empty) begin
      alu_ctrl = head.ctrl;
      alu_a    = head.acc_sel ? acc : head.a;
      alu_b    = head.b;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_ctrl, bus.in_acc_sel, bus.in_a, bus.in_b};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, issue})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_carry <= 1'b0;
      bus.res_zero  <= 1'b0;
    end else if (issue) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= alu_out;
      bus.res_carry <= alu_carry;
      bus.res_zero  <= alu_zero;
    end else if (bus.res_valid && bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

  // A clear wins over the issue update; the captured result already used the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (issue) begin
      acc <= alu_out;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a behavioural ALU closes the loop, a reference
// model predicts each accepted command's result and a monitor checks results as they leave.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  localparam int WIDTH = 6;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic             carry;
    logic             zero;
    logic [WIDTH-1:0] data;
  } res_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   acc_clr = 1'b0;
  logic [3:0]             alu_ctrl;
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [WIDTH-1:0]       alu_out;
  logic                   alu_carry;
  logic                   alu_zero;
  logic [$clog2(DEPTH):0] fifo_level;
  res_t                   alu_r;

  res_t             exp_q[$];
  res_t             mon_exp;
  res_t             held_val;
  logic             held_flag = 1'b0;
  logic [WIDTH-1:0] model_acc = '0;
  bit               rand_mode = 1'b0;
  int               vectors = 0;
  int               miscompares = 0;
  int               accepted_cnt;
  bit               acc_ok;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .acc_clr    (acc_clr),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic res_t alu_fn(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
    logic [WIDTH:0] wide;
    res_t r;
    r = '0;
    case (c)
      4'h0: r.data = a & b;
      4'h1: r.data = a | b;
      4'h2: begin wide = {1'b0, a} + {1'b0, b}; r.data = wide[WIDTH-1:0]; r.carry = wide[WIDTH]; end
      4'h3: r.data = a << b;
      4'h4: r.data = a ^ b;
      4'h5: r.data = a >> b;
      4'h6: begin wide = {1'b0, a} - {1'b0, b}; r.data = wide[WIDTH-1:0]; r.carry = wide[WIDTH]; end
      4'h7: r.data = $signed(a) >>> b;
      4'h8: r.data = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r.data = '0;
    endcase
    r.zero = (r.data == '0);
    return r;
  endfunction

  assign alu_r     = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_out   = alu_r.data;
  assign alu_carry = alu_r.carry;
  assign alu_zero  = alu_r.zero;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Monitor: every result handshake is matched against the oldest prediction; a stalled
  // result must not change while it waits.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      held_flag = 1'b0;
    end else begin
      if (held_flag && bus.res_valid)
        checkOutput("hold_stable", {bus.res_carry, bus.res_zero, bus.res_data}, held_val);
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_result: got data 0x%0h, expected no result", bus.res_data);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("result", {bus.res_carry, bus.res_zero, bus.res_data}, mon_exp);
        end
      end
      held_flag = bus.res_valid && !bus.res_ready;
      held_val  = {bus.res_carry, bus.res_zero, bus.res_data};
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) bus.res_ready = 1'($urandom_range(0, 1));
  end

  // One push attempt lasting one cycle; entered and left at 1 ns after a rising edge.
  task automatic applyStimulus(input logic [3:0] c, input logic sel, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, output bit accepted);
    res_t e;
    bus.in_valid   = 1'b1;
    bus.in_ctrl    = c;
    bus.in_acc_sel = sel;
    bus.in_a       = a;
    bus.in_b       = b;
    @(negedge clk);
    accepted = bus.in_ready;
    if (accepted) begin
      e = alu_fn(c, sel ? model_acc : a, b);
      model_acc = e.data;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pushRetry(input logic [3:0] c, input logic sel, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) applyStimulus(c, sel, a, b, ok);
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL push_timeout: got in_ready stuck low, expected acceptance within 64 cycles");
    end
  endtask

  // Single command into an idle pipeline: not valid one negedge after acceptance, valid the next.
  task automatic directResult(input string name, input logic [3:0] c, input logic sel,
                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] data, input logic carry, input logic zero);
    bit ok;
    applyStimulus(c, sel, a, b, ok);
    checkOutput({name, "_accept"}, 32'(ok), 32'd1);
    @(negedge clk);
    checkOutput({name, "_latency"}, 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    checkOutput({name, "_valid"}, 32'(bus.res_valid), 32'd1);
    checkOutput(name, {bus.res_carry, bus.res_zero, bus.res_data}, {carry, zero, data});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    bus.res_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 300 && !(exp_q.size() == 0 && fifo_level == '0 && !bus.res_valid));
    checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);
    checkOutput("drain_level", 32'(fifo_level), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_valid"}, 32'(bus.res_valid), 32'd0);
    checkOutput({name, "_res"}, {bus.res_carry, bus.res_zero, bus.res_data}, 32'd0);
    checkOutput({name, "_level"}, 32'(fifo_level), 32'd0);
    checkOutput({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({name, "_alu"}, {alu_ctrl, alu_a, alu_b}, 32'd0);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_ctrl    = '0;
    bus.in_acc_sel = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.res_ready  = 1'b1;
    #2;
    checkResetState("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    directResult("add_5_7", 4'h2, 1'b0, 6'd5, 6'd7, 6'd12, 1'b0, 1'b0);
    directResult("sub_3_5", 4'h6, 1'b0, 6'd3, 6'd5, 6'd62, 1'b1, 1'b0);
    directResult("and_zero", 4'h0, 1'b0, 6'h2A, 6'h15, 6'd0, 1'b0, 1'b1);
    directResult("unlisted", 4'hB, 1'b0, 6'd9, 6'd3, 6'd0, 1'b0, 1'b1);

    // Accumulator chain 10, 20, 40, then a clear coinciding with an issue.
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr   = 1'b0;
    model_acc = '0;
    directResult("acc_add1", 4'h2, 1'b1, 6'd33, 6'd10, 6'd10, 1'b0, 1'b0);
    directResult("acc_add2", 4'h2, 1'b1, 6'd33, 6'd10, 6'd20, 1'b0, 1'b0);
    directResult("acc_sll", 4'h3, 1'b1, 6'd33, 6'd1, 6'd40, 1'b0, 1'b0);
    applyStimulus(4'h2, 1'b1, 6'd0, 6'd1, acc_ok);
    acc_clr   = 1'b1;
    model_acc = '0;
    fork
      begin
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
      end
    join_none
    applyStimulus(4'h2, 1'b1, 6'd0, 6'd3, acc_ok);
    @(negedge clk);
    checkOutput("acc_pre_clear", 32'(bus.res_data), 32'd41);
    @(negedge clk);
    checkOutput("acc_post_clear", 32'(bus.res_data), 32'd3);
    @(posedge clk);
    #1;
    drain();

    // Backpressure: DEPTH+1 accepted, head result held, then released one per cycle.
    bus.res_ready = 1'b0;
    accepted_cnt = 0;
    for (int b = 1; b <= 6; b++) begin
      applyStimulus(4'h2, 1'b0, 6'd1, 6'(b), acc_ok);
      if (acc_ok) accepted_cnt++;
    end
    checkOutput("bp_accepted", 32'(accepted_cnt), 32'd5);
    checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_level", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_held", 32'(bus.res_data), 32'd2);
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_stream_valid", 32'(bus.res_valid), 32'd1);
      checkOutput("bp_stream", 32'(bus.res_data), 32'(i + 2));
    end
    @(posedge clk);
    #1;
    drain();

    // Steady level 2 with a push and a pop every cycle.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) pushRetry(4'h2, 1'b0, 6'd0, 6'($urandom));
    checkOutput("steady_start", 32'(fifo_level), 32'd2);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'h4, 1'b0, 6'($urandom), 6'($urandom), acc_ok);
      checkOutput("steady_level", 32'(fifo_level), 32'd2);
    end
    drain();

    // Randomized traffic with random result backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        pushRetry(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom));
      end
    end
    rand_mode = 1'b0;
    drain();

    // Reset mid-stream: everything discarded, no stray result afterwards.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) pushRetry(4'h1, 1'b0, 6'($urandom), 6'($urandom));
    checkOutput("mid_level", 32'(fifo_level), 32'd3);
    checkOutput("mid_valid", 32'(bus.res_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkResetState("mid_reset");
    exp_q.delete();
    model_acc = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 32'(bus.res_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    directResult("post_reset_acc", 4'h2, 1'b1, 6'd20, 6'd5, 6'd5, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
